mio_copy_master: RTL and testbench
==================================

Name: mio_copy_master

Overview:
- Alternate initiator on the MIO bus. Copies a block of 32-bit words from a source address range to a destination address range.
- Typical use: RAM_B frame buffer into the life-game block memory while the CPU is held off.
- Drives the same signal set the CPU drives into MIO_BUS: address, write data and write strobe. Honours MIO_ready.
- bus_req steers the top-level initiator mux (CPU vs. this block).

Parameters:
- CNT_W, 8, width of word_count and words_done; maximum transfer is 2^CNT_W-1 words.
- ADDR_STEP, 4, byte increment applied to both addresses after each word.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous abort; effective in any non-IDLE state.
- src_addr  in  32  source byte address, latched on accepted start.
- dst_addr  in  32  destination byte address, latched on accepted start.
- word_count  in  CNT_W  number of words, latched on accepted start.
- Cpu_data4bus  in  32  read data returned by MIO_BUS.
- MIO_ready  in  1  bus ready; a bus phase completes at an edge where it is 1.
- addr_bus  out  32  bus address.
- Cpu_data2bus  out  32  bus write data.
- mem_w  out  1  write strobe.
- bus_req  out  1  high while this block owns the bus.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- words_done  out  CNT_W  words successfully written in the current/last transfer.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, internal src/dst/remaining/data registers 0. Reset mid-transfer abandons it with no done pulse.
- FSM states: IDLE, RD, RD_CAP, WR, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: bus_req=0, mem_w=0, addr_bus=0.
  - start=1 latches src/dst/count and clears words_done.
  - count≠0 -> RD; count=0 -> DONE (no bus cycles).
- RD: bus_req=1, addr_bus=src, mem_w=0. MIO_ready=1 -> RD_CAP, else stay.
- RD_CAP: addr_bus=src held. Cpu_data4bus is captured into the data register on the exit edge. -> WR unconditionally.
- WR: addr_bus=dst, Cpu_data2bus=data register, mem_w=1. On MIO_ready=1:
  - words_done+1, remaining-1, src+=ADDR_STEP, dst+=ADDR_STEP.
  - Go to DONE if remaining was 1, else RD.
  - MIO_ready=0 holds all WR outputs stable.
- DONE: bus_req=1 for this last cycle, mem_w=0, done=1 for exactly one cycle. -> IDLE.
- Latency: with MIO_ready tied 1, each word takes 3 cycles. An N-word copy is busy for 3N+1 cycles; done is asserted in the final cycle.
- Address arithmetic is modulo 2^32; wrap-around through 0xFFFFFFFC is not an error.
- Cpu_data2bus holds the last written value outside WR. It is 0 only after reset.
- start while busy is ignored; no queueing.
- abort=1 in RD, RD_CAP or WR -> DONE on the next edge, done pulses.
  - If abort and MIO_ready are both 1 in WR on the same edge, that write is counted: words_done increments.
  - abort in DONE has no effect.
  - abort and start in IDLE: start wins, abort ignored.
- words_done holds its value in IDLE until the next accepted start.

Optional Feature:
- Macro MIO_COPY_FILL_EN.
- Defined: adds inputs fill (1) and fill_value (32), latched on start.
  - fill=1 skips RD/RD_CAP and loads the data register with fill_value.
  - The FSM goes IDLE -> WR -> WR ... -> DONE, giving 1 cycle/word and N+1 busy cycles.
  - src_addr is unused in this mode.
- Not defined: ports absent, copy mode only; behaviour exactly as above.

Test Plan:
- Copy, src=0x00000100, dst=0xC0000000, count=3, MIO_ready=1, RAM holds 0x11,0x22,0x33:
  - Writes 0x11@0xC0000000, 0x22@0xC0000004, 0x33@0xC0000008.
  - busy for 10 cycles, done pulse in cycle 10, words_done=3.
- Same copy with MIO_ready low for 2 cycles in the first RD and 3 cycles in the second WR:
  - Outputs stable during stalls, identical data written.
  - busy lasts 15 cycles.
- count=0:
  - busy 1 cycle, done pulse, mem_w never asserted, words_done=0.
- count=5, abort asserted at the same edge MIO_ready=1 completes the 2nd WR:
  - words_done=2, done next cycle, no further mem_w.
- rst pulsed in RD_CAP of word 2:
  - All outputs 0 immediately, no done pulse.
  - A subsequent start behaves normally.
- MIO_COPY_FILL_EN, fill=1, fill_value=0xDEADBEEF, dst=0xFFFFFFF8, count=4:
  - Writes at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
  - busy 5 cycles, words_done=4.

Source files
------------

// File: rtl/mio_copy_master.sv
// mio_copy_master: alternate MIO bus initiator that copies a block of 32-bit
// words from a source range to a destination range. It drives the same
// address, write-data and write-strobe set the CPU drives into MIO_BUS, and it
// waits on MIO_ready for every bus phase.
//
// Optional feature, guarded by the macro MIO_COPY_FILL_EN: adds the fill and
// fill_value inputs. With fill=1 the read phases are skipped and every
// destination word is written with fill_value, at one word per cycle.
// Without the macro the block does copies only.
module mio_copy_master #(
  parameter int          CNT_W     = 8,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
`ifdef MIO_COPY_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_value,
`endif
  input  logic [31:0]      Cpu_data4bus,
  input  logic             MIO_ready,
  output logic [31:0]      addr_bus,
  output logic [31:0]      Cpu_data2bus,
  output logic             mem_w,
  output logic             bus_req,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_CAP = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;
  logic             fill_q, fill_d;

  // Fill mode is a latched copy of the fill input; without the feature it is
  // permanently off and the WR state always returns to RD.
  logic             fill_in;
  logic [31:0]      fill_value_in;
`ifdef MIO_COPY_FILL_EN
  assign fill_in       = fill;
  assign fill_value_in = fill_value;
`else
  assign fill_in       = 1'b0;
  assign fill_value_in = 32'd0;
`endif

  logic last_word;
  assign last_word = (rem_q == CNT_W'(1));

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      data_q       <= '0;
      words_done_q <= '0;
      fill_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      words_done_q <= words_done_d;
      fill_q       <= fill_d;
    end
  end

  // Next-state logic: abort wins over the bus handshake in the active states.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) state_d = S_DONE;
          else if (fill_in)     state_d = S_WR;
          else                  state_d = S_RD;
        end
      end
      S_RD: begin
        if (abort)          state_d = S_DONE;
        else if (MIO_ready) state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        state_d = abort ? S_DONE : S_WR;
      end
      S_WR: begin
        if (abort || (MIO_ready && last_word)) state_d = S_DONE;
        else if (MIO_ready)                    state_d = fill_q ? S_WR : S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch the request on start, capture read data, and
  // advance pointers and counters on each completed write.
  always_comb begin
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    data_d       = data_q;
    words_done_d = words_done_q;
    fill_d       = fill_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          rem_d        = word_count;
          words_done_d = '0;
          fill_d       = fill_in;
          // Only preload when words will actually be written, so the write
          // data output keeps showing the last value really written.
          if (fill_in && (word_count != '0)) data_d = fill_value_in;
        end
      end
      S_RD_CAP: begin
        if (!abort) data_d = Cpu_data4bus;
      end
      S_WR: begin
        // A write completing on the same edge as abort still counts.
        if (MIO_ready) begin
          words_done_d = words_done_q + CNT_W'(1);
          rem_d        = rem_q - CNT_W'(1);
          src_d        = src_q + ADDR_STEP;
          dst_d        = dst_q + ADDR_STEP;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers only; no input reaches them.
  always_comb begin
    addr_bus     = 32'd0;
    mem_w        = 1'b0;
    bus_req      = (state_q != S_IDLE);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    Cpu_data2bus = data_q;
    words_done   = words_done_q;
    unique case (state_q)
      S_RD, S_RD_CAP: addr_bus = src_q;
      S_WR: begin
        addr_bus = dst_q;
        mem_w    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mio_copy_master.sv
// Self-checking bench for mio_copy_master. A small RAM model answers reads,
// a scoreboard queue holds the writes each transfer must produce, and a
// table of transfers is applied in a loop. Reset mid-transfer is a separate
// hand-written sequence. Build with +define+MIO_COPY_FILL_EN to add the fill
// vector.
module tb_mio_copy_master;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [CNT_W-1:0] word_count;
  logic             fill;
  logic [31:0]      fill_value;
  logic [31:0]      Cpu_data4bus;
  logic             MIO_ready;
  logic [31:0]      addr_bus;
  logic [31:0]      Cpu_data2bus;
  logic             mem_w;
  logic             bus_req;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_done;

  mio_copy_master #(.CNT_W(CNT_W), .ADDR_STEP(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .word_count   (word_count),
`ifdef MIO_COPY_FILL_EN
    .fill         (fill),
    .fill_value   (fill_value),
`endif
    .Cpu_data4bus (Cpu_data4bus),
    .MIO_ready    (MIO_ready),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (Cpu_data2bus),
    .mem_w        (mem_w),
    .bus_req      (bus_req),
    .busy         (busy),
    .done         (done),
    .words_done   (words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM model: the three test-plan words at 0x100, a hash of the address elsewhere.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_0011;
      32'h0000_0104: return 32'h0000_0022;
      32'h0000_0108: return 32'h0000_0033;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always_comb Cpu_data4bus = mem_val(addr_bus);

  // Scoreboard of expected writes, in order.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  // Every cycle the strobe is up must match the head of the queue (this also
  // catches outputs moving during a stall); the entry retires when ready is 1.
  always @(negedge clk) begin
    if (mem_w !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", addr_bus, Cpu_data2bus);
      end else begin
        check("wr_addr", addr_bus, sb[0].addr);
        check("wr_data", Cpu_data2bus, sb[0].data);
        if (MIO_ready) void'(sb.pop_front());
      end
    end
  end

  typedef struct {
    string            name;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [CNT_W-1:0] count;
    logic             fill;
    logic [31:0]      fill_value;
    logic [63:0]      ready_low;   // bit c: MIO_ready low in busy cycle c
    int               abort_cyc;   // 0: no abort
    int               restart_cyc; // 0: no extra start while busy
    int               exp_busy;
    int               exp_words;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int busy_cnt, done_cnt, done_cyc;
    logic [31:0] last_data;
    last_data = 32'd0;
    for (int i = 0; i < v.exp_words; i++) begin
      wr_t w;
      w.addr = v.dst + 32'(4 * i);
      w.data = v.fill ? v.fill_value : mem_val(v.src + 32'(4 * i));
      sb.push_back(w);
      last_data = w.data;
    end
    @(posedge clk); #1;
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; word_count = v.count;
    fill = v.fill; fill_value = v.fill_value; MIO_ready = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c < 64; c++) begin
      MIO_ready = ~v.ready_low[c];
      abort     = (c == v.abort_cyc);
      if (c == v.restart_cyc) begin
        start = 1'b1; word_count = CNT_W'(1); dst_addr = 32'h0000_0900;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (!busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; MIO_ready = 1'b1;
    check({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);
    check({v.name, "_done_pulses"}, done_cnt, 1);
    check({v.name, "_done_cycle"}, done_cyc, v.exp_busy);
    check({v.name, "_words_done"}, 32'(words_done), v.exp_words);
    check({v.name, "_writes_left"}, sb.size(), 0);
    if (v.exp_words > 0) check({v.name, "_data_hold"}, Cpu_data2bus, last_data);
    sb.delete();
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] src, input logic [31:0] dst,
                              input int count, input logic [63:0] ready_low, input int abort_cyc,
                              input int restart_cyc, input int exp_busy, input int exp_words);
    vec_t v;
    v.name = name; v.src = src; v.dst = dst; v.count = CNT_W'(count);
    v.fill = 1'b0; v.fill_value = 32'd0; v.ready_low = ready_low;
    v.abort_cyc = abort_cyc; v.restart_cyc = restart_cyc;
    v.exp_busy = exp_busy; v.exp_words = exp_words;
    return v;
  endfunction

  initial begin
    vec_t fv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_addr = '0; dst_addr = '0;
    word_count = '0; fill = 1'b0; fill_value = '0; MIO_ready = 1'b1;

    // Copy, stalled copy, empty copy, aborts, start-while-busy, address wrap.
    vecs.push_back(mk("copy3",      32'h0000_0100, 32'hC000_0000, 3, 64'h0,   0, 0, 10, 3));
    vecs.push_back(mk("stall3",     32'h0000_0100, 32'hC000_0000, 3, 64'h706, 0, 0, 15, 3));
    vecs.push_back(mk("count0",     32'h0000_0100, 32'hC000_0000, 0, 64'h0,   0, 0, 1,  0));
    vecs.push_back(mk("abort_wr2",  32'h0000_0200, 32'h0000_0300, 5, 64'h0,   6, 0, 7,  2));
    vecs.push_back(mk("abort_rdcap",32'h0000_0200, 32'h0000_0300, 4, 64'h0,   2, 0, 3,  0));
    vecs.push_back(mk("abort_done", 32'h0000_0104, 32'h0000_0600, 1, 64'h0,   4, 0, 4,  1));
    vecs.push_back(mk("restart",    32'h0000_0100, 32'h0000_0500, 2, 64'h0,   0, 3, 7,  2));
    vecs.push_back(mk("wrap",       32'hFFFF_FFFC, 32'hFFFF_FFF8, 3, 64'h0,   0, 0, 10, 3));
`ifdef MIO_COPY_FILL_EN
    fv = mk("fill4", 32'h1234_5678, 32'hFFFF_FFF8, 4, 64'h0, 0, 0, 5, 4);
    fv.fill = 1'b1; fv.fill_value = 32'hDEAD_BEEF;
    vecs.push_back(fv);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy), 0);
    check("rst_bus_req",  32'(bus_req), 0);
    check("rst_mem_w",    32'(mem_w), 0);
    check("rst_done",     32'(done), 0);
    check("rst_addr",     addr_bus, 0);
    check("rst_wdata",    Cpu_data2bus, 0);
    check("rst_words",    32'(words_done), 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed in RD_CAP of word 2: only word 1 is ever written.
    begin
      wr_t w;
      w.addr = 32'h0000_0400; w.data = 32'h0000_0011;
      sb.push_back(w);
    end
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h0000_0400; word_count = CNT_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_rdcap_addr", addr_bus, 32'h0000_0104);
    check("pre_rst_words", 32'(words_done), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",    32'(busy), 0);
    check("mid_rst_bus_req", 32'(bus_req), 0);
    check("mid_rst_addr",    addr_bus, 0);
    check("mid_rst_wdata",   Cpu_data2bus, 0);
    check("mid_rst_words",   32'(words_done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(done), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_writes_left", sb.size(), 0);
    sb.delete();
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
